// File: rtl/stream_sink_monitor.sv
// stream_sink_monitor: issues one input-control token after reset, then sinks N_CH
// {data, eos} streams, counting and checksumming each until end-of-stream, and reports
// completion or an idle timeout.
// Optional feature: define STREAM_MON_BACKPRESSURE_EN to gate the ready outputs with a
// 16-bit Fibonacci LFSR (taps 16,14,13,11) so the producer sees pseudo-random stalls.

module stream_sink_monitor #(
    parameter int unsigned N_CH            = 2,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned TIMEOUT         = 1024,
    parameter bit          REQUIRE_OUTCTRL = 1'b1,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   inCtrl_valid,
    input  logic                   inCtrl_ready,
    input  logic                   outCtrl_valid,
    output logic                   outCtrl_ready,
    input  logic [N_CH-1:0]        s_valid,
    output logic [N_CH-1:0]        s_ready,
    input  logic [N_CH*DATA_W-1:0] s_data,
    input  logic [N_CH-1:0]        s_eos,
    output logic [N_CH*CNT_W-1:0]  count,
    output logic [N_CH*DATA_W-1:0] checksum,
    output logic [N_CH-1:0]        eos_seen,
    output logic                   done,
    output logic                   timeout,
    output logic                   err
);

    localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] TMO_LIM  = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
        $error("stream_sink_monitor: N_CH must be in 1..16");
    end
    if (LFSR_SEED == 16'h0) begin : g_bad_seed
        $error("stream_sink_monitor: LFSR_SEED must be nonzero");
    end

    typedef enum logic [2:0] {StIdle, StFire, StRun, StDone, StTmo} state_e;

    state_e                  state_q, state_d;
    logic                    in_valid_q, in_valid_d;
    logic                    out_ready_q, out_ready_d;
    logic [N_CH-1:0]         s_ready_q, s_ready_d;
    logic [N_CH*CNT_W-1:0]   count_q, count_d;
    logic [N_CH*DATA_W-1:0]  sum_q, sum_d;
    logic [N_CH-1:0]         eos_q, eos_d;
    logic                    err_q, err_d;
    logic                    octrl_q, octrl_d;
    logic                    done_q, timeout_q;
    logic [IDLE_W-1:0]       idle_q, idle_d;

    logic [N_CH-1:0]         beat, data_acc, eos_acc, late_acc;
    logic                    octrl_acc, in_hs, activity, finished, tmo_hit;
    logic                    ready_state_d;

    assign beat      = s_valid & s_ready_q;
    assign data_acc  = beat & ~s_eos & ~eos_q;
    assign eos_acc   = beat & s_eos & ~eos_q;
    assign late_acc  = beat & eos_q;
    assign octrl_acc = outCtrl_valid & out_ready_q;
    assign in_hs     = in_valid_q & inCtrl_ready;
    assign activity  = (|beat) | octrl_acc;

    // Status flags, including beats accepted this cycle so DONE sees them immediately.
    always_comb begin
        eos_d    = eos_q | eos_acc;
        err_d    = err_q | (|late_acc);
        octrl_d  = octrl_q | octrl_acc;
        finished = (&eos_d) && (octrl_d || !REQUIRE_OUTCTRL);
        tmo_hit  = (TIMEOUT != 0) && (idle_q == TMO_LIM);
    end

    // Per-stream saturating element counters and wrapping checksums.
    always_comb begin
        count_d = count_q;
        sum_d   = sum_q;
        for (int i = 0; i < N_CH; i++) begin
            if (data_acc[i]) begin
                if (count_q[i*CNT_W +: CNT_W] != CNT_MAX) begin
                    count_d[i*CNT_W +: CNT_W] = count_q[i*CNT_W +: CNT_W] + CNT_ONE;
                end
                sum_d[i*DATA_W +: DATA_W] = sum_q[i*DATA_W +: DATA_W]
                                          + s_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Idle counter runs only in RUN; holds at the limit so it cannot wrap.
    always_comb begin
        idle_d = '0;
        if (state_q == StRun && !activity && idle_q != TMO_LIM) begin
            idle_d = idle_q + IDLE_ONE;
        end
    end

    // Next-state logic; inCtrl_valid rises one cycle into FIRE and drops on the handshake.
    always_comb begin
        state_d    = state_q;
        in_valid_d = 1'b0;
        case (state_q)
            StIdle: state_d = StFire;
            StFire: begin
                in_valid_d = ~in_hs;
                if (in_hs) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (finished) begin
                    state_d = StDone;
                end else if (tmo_hit) begin
                    state_d = StTmo;
                end
            end
            StDone: state_d = StDone;
            StTmo:  state_d = StTmo;
            default: state_d = StIdle;
        endcase
    end

    assign ready_state_d = (state_d == StRun) || (state_d == StDone) || (state_d == StTmo);

`ifdef STREAM_MON_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // LFSR advances only while the sink is accepting data.
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = lfsr_q;
        if (state_q == StRun || state_q == StDone || state_q == StTmo) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end
        s_ready_d   = {N_CH{ready_state_d}} & lfsr_d[N_CH-1:0];
        out_ready_d = ready_state_d & lfsr_d[15];
    end

    // LFSR state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Ready follows the state alone.
    always_comb begin
        s_ready_d   = {N_CH{ready_state_d}};
        out_ready_d = ready_state_d;
    end
`endif

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b0;
            s_ready_q   <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            eos_q       <= '0;
            err_q       <= 1'b0;
            octrl_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_valid_q  <= in_valid_d;
            out_ready_q <= out_ready_d;
            s_ready_q   <= s_ready_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            eos_q       <= eos_d;
            err_q       <= err_d;
            octrl_q     <= octrl_d;
            done_q      <= (state_d == StDone);
            timeout_q   <= (state_d == StTmo);
            idle_q      <= idle_d;
        end
    end

    assign inCtrl_valid  = in_valid_q;
    assign outCtrl_ready = out_ready_q;
    assign s_ready       = s_ready_q;
    assign count         = count_q;
    assign checksum      = sum_q;
    assign eos_seen      = eos_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign err           = err_q;

endmodule
